// File: rtl/alu_cmd_driver.sv
// Command-side driver for the 8-bit ALU: buffers commands in a FIFO, issues them one
// at a time, captures the ALU result and returns it with tag and status flags.
module alu_cmd_driver #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [1:0]       dbg_state
);

    // Handshake rule on both interfaces: a transfer happens on a rising edge where
    // valid && ready are both high; the source holds its payload until that edge.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] fifo_a   [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_b   [FIFO_DEPTH];
    logic [1:0]       fifo_op  [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, handshake;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign handshake = (state == RESP) && rsp_ready;
    assign busy      = (state != IDLE) || !empty;
    assign dbg_state = state;

    // Payload storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_next;
            // alu_* only change on a pop, so they hold the last issued command otherwise.
            if (pop) begin
                alu_a      <= fifo_a[rd_ptr];
                alu_b      <= fifo_b[rd_ptr];
                alu_opcode <= fifo_op[rd_ptr];
                tag_q      <= fifo_tag[rd_ptr];
                err_q      <= fifo_op[rd_ptr][1];
            end
            if (state == ISSUE) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
                rsp_err    <= err_q;
                rsp_tag    <= tag_q;
            end
            if (handshake) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: includes a behavioural ALU, a response scoreboard fed by
// a plain-arithmetic reference model, and directed plus randomized scenarios.
module tb_alu_cmd_driver;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int RW    = TAG_W + WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [1:0]       alu_opcode;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_zero, rsp_err, busy;
  logic [15:0]      op_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rand_ready = 1'b0;

  logic [RW-1:0] exp_q[$];
  int            hs_cyc_q[$];

  alu_cmd_driver #(.WIDTH(WIDTH), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // behavioural ALU
  assign alu_result = (alu_opcode == 2'b00) ? alu_a + alu_b :
                      (alu_opcode == 2'b01) ? alu_a - alu_b : '0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end

  // reference model: expected {tag, result, zero, err}
  function automatic logic [RW-1:0] model(input int a, input int b, input int op, input int tag);
    int r;
    case (op)
      0:       r = (a + b) % 256;
      1:       r = (a - b + 256) % 256;
      default: r = 0;
    endcase
    return {TAG_W'(tag), WIDTH'(r), (r == 0), (op >= 2)};
  endfunction

  // scoreboard + hold-stability monitor
  logic          prev_hold = 1'b0;
  logic [RW-1:0] prev_rsp;
  always @(negedge clk) begin
    logic [RW-1:0] got, exp;
    #1;
    got = {rsp_tag, rsp_result, rsp_zero, rsp_err};
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_checks++;
        if (!rsp_valid || got !== prev_rsp) begin
          n_fail++;
          $display("FAIL rsp_stable: got valid=%0b rsp=%h, required valid=1 rsp=%h", rsp_valid, got, prev_rsp);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp=%h, required no response", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rsp_data: got {tag,res,z,e}=%h, required %h", got, exp);
          end
        end
        hs_cyc_q.push_back(cyc);
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = got;
    end
  end

  // driver tasks
  task automatic push_cmd(input int a, input int b, input int op, input int tag);
    bit done = 0;
    cmd_a = WIDTH'(a); cmd_b = WIDTH'(b); cmd_op = 2'(op); cmd_tag = TAG_W'(tag);
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready) begin
        exp_q.push_back(model(a, b, op, tag));
        done = 1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got cmd_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic wait_idle(input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy, exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, busy, cmd_ready, op_count, alu_a, alu_b, alu_opcode, rsp_result, rsp_tag, rsp_zero, rsp_err} !==
        {1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 8'h0, 2'b0, 8'h0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b busy=%0b ready=%0b cnt=%h alu=%h/%h/%h, required 0/0/1/0/0",
               rsp_valid, busy, cmd_ready, op_count, alu_a, alu_b, alu_opcode);
    end
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b0;
    push_cmd(8'h10, 8'h20, 0, 3);           // edge N accepted
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n: got rsp_valid=%0b, required 0", rsp_valid); end
    @(negedge clk);                          // after N+1: ISSUE
    n_checks++;
    if ({alu_a, alu_b, alu_opcode, rsp_valid, dbg_state} !== {8'h10, 8'h20, 2'b00, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL issue_drive: got a=%h b=%h op=%h valid=%0b st=%0d, required 10 20 0 0 1",
               alu_a, alu_b, alu_opcode, rsp_valid, dbg_state);
    end
    @(negedge clk);                          // after N+2
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_err} !== {1'b1, 8'h30, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_rsp: got v=%0b res=%h tag=%0d z=%0b e=%0b, required 1 30 3 0 0",
               rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if ({op_count, rsp_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_done: got cnt=%0d valid=%0b busy=%0b, required 1 0 0", op_count, rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    hs_cyc_q.delete();
    rsp_ready = 1'b1;
    push_cmd(8'hFF, 8'h01, 0, 5);
    push_cmd(8'h05, 8'h07, 1, 6);
    wait_idle(50);
    rsp_ready = 1'b0;
    n_checks++;
    if (hs_cyc_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses, required 2", hs_cyc_q.size());
    end else if (hs_cyc_q[1] - hs_cyc_q[0] != 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, required 2", hs_cyc_q[1] - hs_cyc_q[0]);
    end
  endtask

  task automatic test_illegal_op();
    rsp_ready = 1'b0;
    push_cmd(8'h55, 8'h0A, 3, 9);
    @(negedge clk);
    n_checks++;
    if ({alu_opcode, alu_a, alu_b} !== {2'b11, 8'h55, 8'h0A}) begin
      n_fail++;
      $display("FAIL illegal_drive: got op=%b a=%h b=%h, required 11 55 0a", alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_err, rsp_zero, rsp_tag} !== {1'b1, 8'h00, 1'b1, 1'b1, 4'd9}) begin
      n_fail++;
      $display("FAIL illegal_rsp: got v=%0b res=%h e=%0b z=%0b tag=%0d, required 1 00 1 1 9",
               rsp_valid, rsp_result, rsp_err, rsp_zero, rsp_tag);
    end
    rsp_ready = 1'b1;
    wait_idle(20);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [15:0] base;
    bit acc;
    rsp_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (idx < 6) begin
        cmd_a = 8'(8'h30 + idx); cmd_b = 8'(idx); cmd_op = 2'(idx % 2); cmd_tag = TAG_W'(8 + idx);
        cmd_valid = 1'b1;
        acc = cmd_ready;
        if (acc) exp_q.push_back(model(8'h30 + idx, idx, idx % 2, 8 + idx));
      end else begin
        acc = 0;
      end
      @(negedge clk);
      if (acc) idx++;
    end
    n_checks++;
    if (idx != 5 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got accepted=%0d cmd_ready=%0b valid=%0b, required 5 0 1", idx, cmd_ready, rsp_valid);
    end
    cmd_valid = 1'b0;
    base = op_count;
    rsp_ready = 1'b1;
    wait_idle(60);
    rsp_ready = 1'b0;
    n_checks++;
    if (op_count !== 16'(base + 16'd5) || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got cnt=%0d ready=%0b, required %0d 1", op_count, cmd_ready, base + 5);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_cmd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    wait_idle(400);
    rand_ready = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'h11 + i, 8'h22, 0, i);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd1 || busy !== 1'b1 || rsp_result === 8'h00) begin
      n_fail++;
      $display("FAIL pre_reset: got st=%0d busy=%0b res=%h, required ISSUE busy nonzero", dbg_state, busy, rsp_result);
    end
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({rsp_valid, busy, cmd_ready, op_count, alu_a, alu_opcode, rsp_result, rsp_tag, dbg_state} !==
        {1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 2'b0, 8'h0, 4'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_clear: got valid=%0b busy=%0b ready=%0b cnt=%h a=%h res=%h st=%0d, required 0 0 1 0 0 0 0",
               rsp_valid, busy, cmd_ready, op_count, alu_a, rsp_result, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got seen_rsp=%0b busy=%0b ready=%0b, required 0 0 1", seen, busy, cmd_ready);
    end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    rsp_ready = 1'b1;
    push_cmd(8'h01, 8'h02, 0, 7);
    wait_idle(20);
    rsp_ready = 1'b0;
    n_checks++;
    if (op_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: got op_count=%h, required 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal_op();
    test_backpressure();
    test_random();
    test_async_reset();
    test_count_wrap();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
